// File: rtl/fpmul_pkg.sv
// Shared constants and types for the Q15 sign-magnitude multiplier arbiter slice.
package fpmul_pkg;
  localparam int FP_N        = 32;
  localparam int FP_Q        = 15;
  localparam int FP_SIGN_BIT = FP_N - 1;
  localparam int ARB_CNT_W   = 16;

  typedef logic [FP_N-1:0] fp_word_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);
  always_comb begin
    int c;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(last_i) + k) % NREQ;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        idx_o    = IDW'(c);
        gnt_o[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fpmul_rr_arbiter.sv
// Round-robin front end for a shared combinational Q15 multiplier, 2-stage pipe.
// Optional per-requester grant counters: define FPMUL_ARB_STATS_EN.
module fpmul_rr_arbiter
  import fpmul_pkg::*;
#(
  parameter int N    = FP_N,
  parameter int Q    = FP_Q,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [N-1:0]      mul_a,
  output logic [N-1:0]      mul_b,
  input  logic [N-1:0]      mul_result,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N-1:0]      resp_data,
  output logic [IDW-1:0]    resp_id
`ifdef FPMUL_ARB_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [NREQ*ARB_CNT_W-1:0] grant_cnt
`endif
);
  if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || Q >= N) begin : g_cfg_err
    $error("fpmul_rr_arbiter: illegal parameter set");
  end

  logic [NREQ-1:0][N-1:0] a_v, b_v;
  assign a_v = req_a;
  assign b_v = req_b;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic            any;
  logic            adv1, adv2, accept;

  logic            s1_valid_q, s1_valid_d, resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d, last_q, last_d, resp_id_q, resp_id_d;
  logic [N-1:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d, resp_data_q, resp_data_d;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i (req_valid),
    .last_i(last_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (any)
  );

  // One free slot anywhere in the pipe is enough to take a new operand.
  assign adv2      = !resp_valid_q || resp_ready;
  assign adv1      = !s1_valid_q || adv2;
  assign accept    = any && adv1;
  assign req_ready = gnt & {NREQ{adv1}};

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_id_d      = s1_id_q;
    last_d       = last_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    if (adv1) begin
      s1_valid_d = accept;
      if (accept) begin
        mul_a_d = a_v[gidx];
        mul_b_d = b_v[gidx];
        s1_id_d = gidx;
        last_d  = gidx;
      end
    end
    // mul_result is only looked at on the cycle its operands move into stage 2.
    if (adv2) begin
      resp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        resp_data_d = mul_result;
        resp_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      last_q       <= IDW'(NREQ - 1);
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      last_q       <= last_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

`ifdef FPMUL_ARB_STATS_EN
  logic [NREQ-1:0][ARB_CNT_W-1:0] cnt_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt_q[i] <= '0;
      else if (stats_clr)
        cnt_q[i] <= '0;
      else if (req_valid[i] && req_ready[i] && cnt_q[i] != '1)
        cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_fpmul_rr_arbiter.sv
// Scoreboard bench for fpmul_rr_arbiter with a Q15 sign-magnitude multiplier model.
module tb_fpmul_rr_arbiter;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req_valid, req_ready;
  logic [3:0][31:0] a_v, b_v;
  logic [31:0]      mul_a, mul_b, mul_result, resp_data;
  logic             resp_valid, resp_ready;
  logic [1:0]       resp_id;
`ifdef FPMUL_ARB_STATS_EN
  logic             stats_clr;
  logic [63:0]      grant_cnt;
`endif

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errs    = 0;

  always #5 clk = ~clk;

  fpmul_rr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(a_v), .req_b(b_v),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id)
`ifdef FPMUL_ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt(grant_cnt)
`endif
  );

  // Reference shared multiplier: sign XOR, magnitude product scaled by 2^-15.
  function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
    logic [61:0] p;
    p = 62'(a[30:0]) * 62'(b[30:0]);
    return {a[31] ^ b[31], p[45:15]};
  endfunction

  assign mul_result = fpmul(mul_a, mul_b);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [31:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response handshake must match the next queued expectation.
  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      if (q.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL unexpected_resp: got id %0d data %0h, expected none", resp_id, resp_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp", {30'd0, resp_id, resp_data}, {30'd0, e.id, e.data});
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] c_rdy[5];
    c_rdy = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b1; a_v = '0; b_v = '0;
`ifdef FPMUL_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (2) tick();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    rst_n = 1'b1;

    // First grant after reset goes to requester 0; 1.0 * 2.0 = 2.0.
    a_v[0] = 32'h0000_8000; b_v[0] = 32'h0001_0000;
    req_valid = 4'hF;
    push(2'd0, 32'h0001_0000);
    @(negedge clk); chk("first_grant", 64'(req_ready), 64'h1);
    tick(); req_valid = '0;
    @(negedge clk); chk("lat_cycle1", 64'(resp_valid), 64'd0);
    @(negedge clk); chk("lat_cycle2", 64'(resp_valid), 64'd1);
    repeat (2) tick();

    // Negative operand from requester 3 only: -1.0 * 1.0 = -1.0.
    a_v[3] = 32'h8000_8000; b_v[3] = 32'h0000_8000;
    req_valid = 4'b1000;
    push(2'd3, 32'h8000_8000);
    @(negedge clk); chk("only_req3", 64'(req_ready), 64'h8);
    tick(); req_valid = '0;
    repeat (3) tick();

    // All valid, no stall: 0,1,2,3,0,1,2,3 back to back; (i+1) * 1.5.
    for (int i = 0; i < 4; i++) begin
      a_v[i] = 32'(i + 1) << 15;
      b_v[i] = 32'h0001_8000;
    end
    for (int k = 0; k < 8; k++) push(2'(k % 4), 32'h0001_8000 * 32'((k % 4) + 1));
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      if (k >= 2) chk("rr_no_bubble", 64'(resp_valid), 64'd1);
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); chk("rr_tail", 64'(resp_valid), 64'd1);
      tick();
    end
    @(negedge clk); chk("rr_drained", 64'(resp_valid), 64'd0);
    tick();

    // Stall: two accepts fill the pipe, then ready stays low and output holds.
    resp_ready = 1'b0;
    req_valid  = 4'b0110;
    push(2'd1, 32'h0003_0000);
    push(2'd2, 32'h0004_8000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_ready", 64'(req_ready), 64'(c_rdy[k]));
      if (k >= 2) begin
        chk("stall_hold_id", 64'(resp_id), 64'd1);
        chk("stall_hold_data", 64'(resp_data), 64'h0003_0000);
      end
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (4) tick();

`ifdef FPMUL_ARB_STATS_EN
    // Saturate requester 1's counter, then clear during an accept.
    a_v[1] = 32'h0001_0000; b_v[1] = 32'h0000_8000;
    req_valid = 4'b0010;
    for (int k = 0; k < 70000; k++) begin
      push(2'd1, 32'h0001_0000);
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    chk("cnt1_sat", 64'(grant_cnt[16 +: 16]), 64'hFFFF);
    chk("cnt0", 64'(grant_cnt[0 +: 16]), 64'd3);
    chk("cnt2", 64'(grant_cnt[32 +: 16]), 64'd3);
    chk("cnt3", 64'(grant_cnt[48 +: 16]), 64'd3);
    req_valid = 4'b0010; stats_clr = 1'b1;
    push(2'd1, 32'h0001_0000);
    tick();
    req_valid = '0; stats_clr = 1'b0;
    repeat (3) tick();
    chk("cnt1_clr", 64'(grant_cnt[16 +: 16]), 64'd0);
    chk("cnt0_clr", 64'(grant_cnt[0 +: 16]), 64'd0);
`endif

    // Reset with both stages full: everything in flight is dropped.
    resp_ready = 1'b0;
    a_v[0] = 32'h1234_5678; b_v[0] = 32'h0000_8000;
    req_valid = 4'b0001;
    repeat (2) tick();
    req_valid = '0;
    @(negedge clk); chk("pre_rst_full", 64'(resp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    chk("arst_mul_a", 64'(mul_a), 64'd0);
    chk("arst_resp_data", 64'(resp_data), 64'd0);
    resp_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
